// File: rtl/regfile_pkg.sv
// Shared constants for the GB80 register-file write path: register and pair
// indices, scheduler state encoding, and the F-register low-nibble mask.
package regfile_pkg;

  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;
  localparam logic [2:0] REG_A = 3'd6;
  localparam logic [2:0] REG_F = 3'd7;

  localparam logic [1:0] PAIR_BC = 2'd0;
  localparam logic [1:0] PAIR_DE = 2'd1;
  localparam logic [1:0] PAIR_HL = 2'd2;
  localparam logic [1:0] PAIR_AF = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LO   = 1'b1
  } state_t;

  // F keeps its low nibble at zero no matter what is written.
  localparam logic [7:0] F_LOW_MASK = 8'hF0;

  // Byte register holding half of a pair: lo=0 gives the high byte register.
  function automatic logic [2:0] pair_reg(input logic [1:0] pair, input logic lo);
    return {pair, lo};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the grant goes to the first request after the last
// granted index; the pointer only moves when the grant is actually taken.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    grant = '0;
    gidx  = ptr;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (enable && !found && req[cand]) begin
        grant[cand] = 1'b1;
        gidx        = cand;
        found       = 1'b1;
      end
    end
  end

  // Reset value makes requester 0 the first one searched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= PTR_W'(NUM_REQ - 1);
    end else if (advance) begin
      ptr <= gidx;
    end
  end

endmodule

// File: rtl/regfile_write_sched.sv
// Write-port scheduler for the GB80 byte register file: arbitrates requesters
// onto one registered write path and splits pair writes into high-then-low bytes.
module regfile_write_sched
  import regfile_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic [NUM_REQ-1:0]              i_req_pair,
  input  logic [3*NUM_REQ-1:0]            i_req_idx,
  input  logic [2*DATA_WIDTH*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REGS-1:0]             o_reg_we,
  output logic [DATA_WIDTH-1:0]           o_reg_wdata,
  output logic                            o_busy
);

  localparam logic [DATA_WIDTH-1:0] F_MASK = DATA_WIDTH'(F_LOW_MASK);

  state_t                  state;
  logic [NUM_REQ-1:0]      grant;
  logic                    hs;
  logic                    sel_pair;
  logic [2:0]              sel_idx;
  logic [2*DATA_WIDTH-1:0] sel_data;
  logic [2:0]              lo_idx;
  logic [DATA_WIDTH-1:0]   lo_data;

  function automatic logic [DATA_WIDTH-1:0] f_guard(input logic [2:0] idx,
                                                    input logic [DATA_WIDTH-1:0] d);
    return (idx == REG_F) ? (d & F_MASK) : d;
  endfunction

  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [2:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (i_clk),
    .rst     (i_reset),
    .req     (i_req_valid),
    .enable  (state == ST_IDLE),
    .advance (hs),
    .grant   (grant)
  );

  assign o_req_ready = grant;
  assign hs          = |(i_req_valid & grant);
  assign o_busy      = (state == ST_LO);

  always_comb begin
    sel_pair = 1'b0;
    sel_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_pair = i_req_pair[i];
        sel_idx  = i_req_idx[3*i +: 3];
        sel_data = i_req_data[2*DATA_WIDTH*i +: 2*DATA_WIDTH];
      end
    end
  end

  // The high byte of a pair always lands on an even register, never F.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      o_reg_we    <= '0;
      o_reg_wdata <= '0;
      lo_idx      <= '0;
      lo_data     <= '0;
    end else if (state == ST_LO) begin
      o_reg_we    <= reg_sel(lo_idx);
      o_reg_wdata <= f_guard(lo_idx, lo_data);
      state       <= ST_IDLE;
    end else if (hs && sel_pair) begin
      o_reg_we    <= reg_sel(pair_reg(sel_idx[1:0], 1'b0));
      o_reg_wdata <= sel_data[2*DATA_WIDTH-1:DATA_WIDTH];
      lo_idx      <= pair_reg(sel_idx[1:0], 1'b1);
      lo_data     <= sel_data[DATA_WIDTH-1:0];
      state       <= ST_LO;
    end else if (hs) begin
      o_reg_we    <= reg_sel(sel_idx);
      o_reg_wdata <= f_guard(sel_idx, sel_data[DATA_WIDTH-1:0]);
    end else begin
      o_reg_we    <= '0;
    end
  end

endmodule
